// File: rtl/quad_enc_pos_vel_if.sv
// Bundle connecting the quadrature-encoder count stage to the position/velocity stage.
//   acc[CH]    signed interval edge counts, qualified by acc_valid
//   acc_valid  one-cycle strobe: acc[] holds a new sample
//   clr_pos    synchronous clear of all positions
//   pos[CH]    accumulated signed position
//   vel[CH]    windowed average count per interval
//   vel_ok     averaging window has been filled since reset
//   out_valid  one-cycle strobe: pos/vel updated
// master: the block that produces counts and consumes pos/vel
// slave:  quad_enc_pos_vel
interface quad_enc_pos_vel_if #(
  parameter int CH   = 1,
  parameter int ACCW = 16,
  parameter int POSW = 32
);
  logic signed [ACCW-1:0] acc [CH];
  logic                   acc_valid;
  logic                   clr_pos;
  logic signed [POSW-1:0] pos [CH];
  logic signed [ACCW-1:0] vel [CH];
  logic                   vel_ok;
  logic                   out_valid;

  modport master (
    output acc, acc_valid, clr_pos,
    input  pos, vel, vel_ok, out_valid
  );

  modport slave (
    input  acc, acc_valid, clr_pos,
    output pos, vel, vel_ok, out_valid
  );
endinterface

// File: rtl/quad_enc_pos_vel.sv
// Position / velocity stage of the quadrature encoder interface.
// Per channel: pos is a wrapping running sum of the signed interval counts,
// vel is the floor-average of the last 2**AVG_LOG2 counts (zero-filled until
// the window has seen that many samples). All channels update on the same
// acc_valid strobe; results appear one cycle later with out_valid.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active low
//   bus    quad_enc_pos_vel_if.slave (acc, acc_valid, clr_pos in;
//          pos, vel, vel_ok, out_valid out)
module quad_enc_pos_vel #(
  parameter int CH       = 1,
  parameter int ACCW     = 16,
  parameter int POSW     = 32,
  parameter int AVG_LOG2 = 3
) (
  input logic              clk,
  input logic              rst_n,
  quad_enc_pos_vel_if.slave bus
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = ACCW + AVG_LOG2;
  localparam int WPW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [ACCW-1:0] win_q   [CH][DEPTH];
  logic signed [SW-1:0]   sum_q   [CH];
  logic signed [SW-1:0]   sum_nxt [CH];
  logic [WPW-1:0]         wp_q;
  logic [WPW-1:0]         wp_nxt;
  logic [WPW-1:0]         fill_q;

  // Running sum: add the incoming count, retire the one it overwrites.
  // Unwritten window slots hold zero, giving the zero-filled average early on.
  always_comb begin
    wp_nxt = (32'(wp_q) == DEPTH - 1) ? '0 : wp_q + WPW'(1);
    for (int unsigned c = 0; c < CH; c++) begin
      sum_nxt[c] = sum_q[c] + SW'(bus.acc[c]) - SW'(win_q[c][wp_q]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH; c++) begin
        bus.pos[c] <= '0;
        bus.vel[c] <= '0;
        sum_q[c]   <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          win_q[c][d] <= '0;
        end
      end
      wp_q          <= '0;
      fill_q        <= '0;
      bus.vel_ok    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.acc_valid) begin
      for (int unsigned c = 0; c < CH; c++) begin
        // clr_pos together with a sample: clear first, then add the sample
        bus.pos[c]        <= (bus.clr_pos ? '0 : bus.pos[c]) + POSW'(bus.acc[c]);
        sum_q[c]          <= sum_nxt[c];
        win_q[c][wp_q]    <= bus.acc[c];
        bus.vel[c]        <= ACCW'(sum_nxt[c] >>> AVG_LOG2);
      end
      wp_q          <= wp_nxt;
      bus.out_valid <= 1'b1;
      // fill counter stops once the DEPTH-th sample has landed
      if (!bus.vel_ok) begin
        if (32'(fill_q) == DEPTH - 1) begin
          bus.vel_ok <= 1'b1;
        end else begin
          fill_q <= fill_q + WPW'(1);
        end
      end
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.clr_pos) begin
        for (int unsigned c = 0; c < CH; c++) begin
          bus.pos[c] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_quad_enc_pos_vel.sv
module tb_quad_enc_pos_vel;
  localparam int CH    = 2;
  localparam int ACCW  = 8;
  localparam int POSW  = 16;
  localparam int AVGL  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  quad_enc_pos_vel_if #(.CH(CH), .ACCW(ACCW), .POSW(POSW)) bus ();

  quad_enc_pos_vel #(.CH(CH), .ACCW(ACCW), .POSW(POSW), .AVG_LOG2(AVGL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: history queues of past samples (newest first)
  int h0[$];
  int h1[$];
  int m_pos[2];
  int m_vel[2];
  int m_cnt;
  bit m_ov;

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int win_avg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return floor_div(s, DEPTH);
  endfunction

  task automatic model_reset();
    h0.delete();
    h1.delete();
    m_pos[0] = 0; m_pos[1] = 0;
    m_vel[0] = 0; m_vel[1] = 0;
    m_cnt = 0;
    m_ov = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit clr, input int a0, input int a1);
    m_ov = v;
    if (v) begin
      m_pos[0] = clr ? a0 : m_pos[0] + a0;
      m_pos[1] = clr ? a1 : m_pos[1] + a1;
      m_pos[0] = int'(shortint'(m_pos[0]));
      m_pos[1] = int'(shortint'(m_pos[1]));
      h0.push_front(a0);
      h1.push_front(a1);
      if (h0.size() > DEPTH) void'(h0.pop_back());
      if (h1.size() > DEPTH) void'(h1.pop_back());
      m_vel[0] = win_avg(h0);
      m_vel[1] = win_avg(h1);
      m_cnt++;
    end else if (clr) begin
      m_pos[0] = 0;
      m_pos[1] = 0;
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pos0"}, longint'(bus.pos[0]), longint'(m_pos[0]));
    chk({tag, ".pos1"}, longint'(bus.pos[1]), longint'(m_pos[1]));
    chk({tag, ".vel0"}, longint'(bus.vel[0]), longint'(m_vel[0]));
    chk({tag, ".vel1"}, longint'(bus.vel[1]), longint'(m_vel[1]));
    chk({tag, ".vel_ok"}, longint'(bus.vel_ok), (m_cnt >= DEPTH) ? 1 : 0);
    chk({tag, ".out_valid"}, longint'(bus.out_valid), longint'(m_ov));
  endtask

  task automatic step(input string tag, input bit v, input bit clr, input int a0, input int a1);
    @(negedge clk);
    bus.acc_valid = v;
    bus.clr_pos   = clr;
    bus.acc[0]    = 8'(a0);
    bus.acc[1]    = 8'(a1);
    @(posedge clk);
    #1;
    model_step(v, clr, a0, a1);
    chk_all(tag);
  endtask

  initial begin
    int r0, r1;
    bit v, c;
    rst_n         = 1'b0;
    bus.acc_valid = 1'b0;
    bus.clr_pos   = 1'b0;
    bus.acc[0]    = '0;
    bus.acc[1]    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ramp up with +5, vel 1,2,3,5, vel_ok on the 4th
    for (int i = 0; i < 4; i++) step($sformatf("t1_%0d", i), 1'b1, 1'b0, 5, 0);
    chk("t1.pos0_abs", longint'(bus.pos[0]), 20);
    chk("t1.vel0_abs", longint'(bus.vel[0]), 5);
    step("t1_idle", 1'b0, 1'b0, 0, 0);

    // 2: negative samples, floor rounding
    for (int i = 0; i < 4; i++) step($sformatf("t2_%0d", i), 1'b1, 1'b0, -3, 0);
    chk("t2.vel0_abs", longint'(bus.vel[0]), -3);
    chk("t2.pos0_abs", longint'(bus.pos[0]), 8);

    // 3: wrap from 32766 to -32768
    step("t3_clr", 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 258; i++) step($sformatf("t3_%0d", i), 1'b1, 1'b0, 127, 0);
    chk("t3.pos0_top", longint'(bus.pos[0]), 32766);
    step("t3_wrap", 1'b1, 1'b0, 2, 0);
    chk("t3.pos0_wrap", longint'(bus.pos[0]), -32768);

    // 4: clr_pos with a sample, then clr_pos alone
    step("t4_clradd", 1'b1, 1'b1, 7, 3);
    chk("t4.pos0_abs", longint'(bus.pos[0]), 7);
    step("t4_clr", 1'b0, 1'b1, 0, 0);
    step("t4_hold", 1'b0, 1'b0, 0, 0);

    // 5: back-to-back samples on both channels
    step("t5_clr", 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 20; i++) step($sformatf("t5_%0d", i), 1'b1, 1'b0, 1, -1);
    chk("t5.pos0_abs", longint'(bus.pos[0]), 20);
    chk("t5.pos1_abs", longint'(bus.pos[1]), -20);
    step("t5_idle", 1'b0, 1'b0, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      r0 = int'(byte'($urandom_range(0, 255)));
      r1 = int'(byte'($urandom_range(0, 255)));
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 15) == 0);
      step($sformatf("rnd_%0d", i), v, c, r0, r1);
    end

    // 6: asynchronous reset between edges with a sample pending
    @(posedge clk);
    #2;
    bus.acc_valid = 1'b1;
    bus.acc[0]    = 8'(9);
    bus.acc[1]    = 8'(9);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("t6_async");
    @(posedge clk);
    #1;
    chk_all("t6_held");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.acc_valid = 1'b0;
    step("t6_after", 1'b1, 1'b0, 4, 0);
    chk("t6.pos0_abs", longint'(bus.pos[0]), 4);
    chk("t6.vel0_abs", longint'(bus.vel[0]), 1);
    chk("t6.vel_ok_abs", longint'(bus.vel_ok), 0);
    step("t6_idle", 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
